// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-side, data-side and memory-side
// signals of the memory arbiter.
//   master : arbiter view (samples requests and memory response, drives
//            ready/rdata, memory strobes/buses and err)
//   slave  : environment view (cache controllers + memory model)
// Ports:
//   i_req/i_addr -> i_ready/i_rdata                 instruction-side read path
//   d_req/d_wen/d_addr/d_wdata/d_be -> d_ready/d_rdata   data-side path
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_be <- mem_rdata/mem_done
//   err                                           timeout flag
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              err;

  modport master (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_be,
    input  mem_rdata, mem_done,
    output i_ready, i_rdata, d_ready, d_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_be, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_be,
    output mem_rdata, mem_done,
    input  i_ready, i_rdata, d_ready, d_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_be, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing memory between the instruction-side and
// data-side cache-miss paths. Round-robin between the two requesters, one
// access in flight, registered memory strobes held until mem_done, and a
// one-cycle ready pulse to the winning side.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    mem_arbiter_if.master (requester, memory and err signals)
// Parameters: ADDR_W, DATA_W, TIMEOUT (watchdog limit in BUSY cycles).
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog;
// without it BUSY waits forever for mem_done and err is tied low.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

  typedef struct packed {
    side_t             side;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  state_t            state, state_nxt;
  side_t             last_grant, win_side;
  logic              win_wen;
  logic              grant, finish;
  logic              load_rdata;
  logic [DATA_W-1:0] cpl_data;
  req_t              gnt_req;

  // Winner selection: I wins unless D is also asking and I went last.
  always_comb begin
    gnt_req = '0;
    if (bus.i_req && (!bus.d_req || last_grant == SIDE_D)) begin
      gnt_req.side  = SIDE_I;
      gnt_req.wen   = 1'b0;
      gnt_req.addr  = bus.i_addr;
      gnt_req.wdata = '0;
      gnt_req.be    = '1;
    end else begin
      gnt_req.side  = SIDE_D;
      gnt_req.wen   = bus.d_wen;
      gnt_req.addr  = bus.d_addr;
      gnt_req.wdata = bus.d_wdata;
      gnt_req.be    = bus.d_wen ? bus.d_be : '1;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo;

  // Counts completed BUSY cycles; hitting TIMEOUT-1 means this is the
  // TIMEOUT-th BUSY cycle without mem_done.
  assign tmo = (state == BUSY) && !bus.mem_done &&
               (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             tmo_cnt <= '0;
    else if (grant)         tmo_cnt <= '0;
    else if (state == BUSY) tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.err <= 1'b0;
    else        bus.err <= finish && tmo;
  end

  assign load_rdata = !win_wen || tmo;
  assign cpl_data   = tmo ? DATA_W'(32'hDEADBEEF) : bus.mem_rdata;
`else
  assign bus.err    = 1'b0;
  assign load_rdata = !win_wen;
  assign cpl_data   = bus.mem_rdata;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (bus.i_req || bus.d_req) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.mem_done) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: memory buses are captured at grant and left untouched until
  // the next grant, so they are stable for all of BUSY. Ready is registered
  // on completion, which places the pulse exactly in the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant    <= SIDE_D;
      win_side      <= SIDE_I;
      win_wen       <= 1'b0;
      bus.mem_ren   <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.i_ready   <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      if (grant) begin
        last_grant    <= gnt_req.side;
        win_side      <= gnt_req.side;
        win_wen       <= gnt_req.wen;
        bus.mem_addr  <= gnt_req.addr;
        bus.mem_wdata <= gnt_req.wdata;
        bus.mem_be    <= gnt_req.be;
        bus.mem_ren   <= !gnt_req.wen;
        bus.mem_wen   <= gnt_req.wen;
      end
      if (finish) begin
        bus.mem_ren <= 1'b0;
        bus.mem_wen <= 1'b0;
        if (win_side == SIDE_I) begin
          bus.i_ready <= 1'b1;
          if (load_rdata) bus.i_rdata <= cpl_data;
        end else begin
          bus.d_ready <= 1'b1;
          if (load_rdata) bus.d_rdata <= cpl_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench for mem_arbiter. A memory
// responder answers strobes after a programmable latency (and toggles
// mem_done/mem_rdata randomly while idle); a transaction-level model
// predicts grant order, strobe windows, ready timing and returned data.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 8;

  typedef struct packed {
    bit          side;   // 0 = I, 1 = D
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  // model state
  bit          last_g;
  logic [31:0] exp_i, exp_d;
  logic [31:0] model_mem [logic [31:0]];

  // responder state
  int          lat   = 0;
  bit          stall = 1'b0;
  int          rcnt  = 0;
  logic [31:0] resp_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_val(a);
  endfunction

  function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    model_mem[a] = merge(mread(a), d, be);
  endfunction

  // Memory responder, driven on the falling edge.
  always @(negedge clk) begin
    logic [31:0] a, cur;
    if (reset && (bus.mem_ren || bus.mem_wen)) begin
      if (!stall && rcnt >= lat) begin
        a   = bus.mem_addr;
        cur = resp_mem.exists(a) ? resp_mem[a] : init_val(a);
        if (bus.mem_wen) resp_mem[a] = merge(cur, bus.mem_wdata, bus.mem_be);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = bus.mem_wen ? $urandom : cur;
      end else begin
        bus.mem_done  = 1'b0;
        bus.mem_rdata = $urandom;
      end
      rcnt++;
    end else begin
      rcnt          = 0;
      bus.mem_done  = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
    end
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    reset     = 1'b0;
    #1;
    chk("reset_state",
        {bus.i_ready, bus.d_ready, bus.mem_ren, bus.mem_wen, bus.err,
         bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.i_rdata, bus.d_rdata}, '0);
    step();
    step();
    reset  = 1'b1;
    last_g = 1'b1;
    exp_i  = '0;
    exp_d  = '0;
  endtask

  task automatic scramble(input bit side);
    if (!side) bus.i_addr = $urandom;
    else begin
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.d_wen   = 1'($urandom_range(0, 1));
      bus.d_be    = 4'($urandom);
    end
  endtask

  // One or two simultaneous requests, presented in an IDLE cycle; checks
  // every cycle until the last expected ready pulse.
  task automatic do_txn(input bit use_i, input acc_t ia, input bit use_d, input acc_t da,
                        input int l);
    acc_t q[2];
    int   n, act;
    int   s[2], r[2];
    bit   ren, wen, ir, dr;
    step();
    lat = l;
    if (use_i && use_d) begin
      if (last_g) begin q[0] = ia; q[1] = da; end
      else        begin q[0] = da; q[1] = ia; end
      n = 2;
    end else if (use_i) begin q[0] = ia; q[1] = ia; n = 1; end
    else                begin q[0] = da; q[1] = da; n = 1; end
    last_g = q[n-1].side;
    s[0] = 0;
    r[0] = l + 1;
    s[1] = r[0] + 2;
    r[1] = s[1] + l + 1;
    if (use_i) begin bus.i_req = 1'b1; bus.i_addr = ia.addr; end
    if (use_d) begin
      bus.d_req = 1'b1; bus.d_wen = da.wen; bus.d_addr = da.addr;
      bus.d_wdata = da.wdata; bus.d_be = da.be;
    end
    for (int e = 0; e <= r[n-1]; e++) begin
      step();
      ren = 0; wen = 0; ir = 0; dr = 0; act = -1;
      for (int k = 0; k < n; k++) begin
        if (e >= s[k] && e <= s[k] + l) begin
          ren = !q[k].wen; wen = q[k].wen; act = k;
        end
        if (e == r[k]) begin
          if (q[k].side) dr = 1; else ir = 1;
          if (!q[k].wen) begin
            if (q[k].side) exp_d = mread(q[k].addr);
            else           exp_i = mread(q[k].addr);
          end else mwrite(q[k].addr, q[k].wdata, q[k].be);
        end
      end
      chk("ctl{ir,dr,ren,wen,err}",
          {bus.i_ready, bus.d_ready, bus.mem_ren, bus.mem_wen, bus.err},
          {ir, dr, ren, wen, 1'b0});
      chk("rdata{i,d}", {bus.i_rdata, bus.d_rdata}, {exp_i, exp_d});
      if (act >= 0) begin
        chk("mem{addr,be}", {bus.mem_addr, bus.mem_be},
            {q[act].addr, q[act].wen ? q[act].be : 4'hF});
        if (q[act].wen) chk("mem_wdata", bus.mem_wdata, q[act].wdata);
      end
      for (int k = 0; k < n; k++) begin
        if (e == s[k]) scramble(q[k].side);
        if (e == r[k]) begin
          if (q[k].side) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        end
      end
    end
  endtask

  function automatic acc_t mk_i(input logic [31:0] a);
    acc_t t;
    t.side = 1'b0; t.wen = 1'b0; t.addr = a; t.wdata = '0; t.be = 4'hF;
    return t;
  endfunction

  function automatic acc_t mk_d(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
    acc_t t;
    t.side = 1'b1; t.wen = w; t.addr = a; t.wdata = d; t.be = be;
    return t;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + 32'($urandom_range(0, 7)) * 4;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ui, ud;
    acc_t ia, da;
    reset = 1'b0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    do_reset();

    // I-only read, memory answers one cycle after the strobe
    resp_mem[32'h100]  = 32'h00500093;
    model_mem[32'h100] = 32'h00500093;
    do_txn(1'b1, mk_i(32'h100), 1'b0, mk_d(0, 0, 0, 0), 1);
    chk("i_only_rdata", bus.i_rdata, 32'h00500093);

    // D partial write; d_rdata must stay untouched
    do_txn(1'b0, mk_i(0), 1'b1, mk_d(1'b1, 32'h2004, 32'hCAFEF00D, 4'b0011), 2);
    chk("d_write_rdata_held", bus.d_rdata, 32'h0);

    // Ties right after reset: I, then D, then I again
    do_reset();
    do_txn(1'b1, mk_i(rnd_addr()), 1'b1, mk_d(1'b0, rnd_addr(), 0, 4'hF), 0);
    do_txn(1'b1, mk_i(rnd_addr()), 1'b1, mk_d(1'b0, 32'h2004, 0, 4'hF), 1);

    // Reset in the middle of BUSY
    step();
    stall = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    step();
    chk("midbusy_ren", bus.mem_ren, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midbusy_drop", {bus.mem_ren, bus.mem_wen, bus.i_ready, bus.d_ready, bus.err}, '0);
    bus.i_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midbusy_noready", {bus.i_ready, bus.d_ready, bus.mem_ren, bus.mem_wen}, '0);
    end
    reset = 1'b1; stall = 1'b0; last_g = 1'b1; exp_i = '0; exp_d = '0;
    do_txn(1'b0, mk_i(0), 1'b1, mk_d(1'b0, 32'h40, 0, 4'hF), 0);

    // Memory never answers
    step();
    stall = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int e = 0; e <= TMO; e++) begin
      step();
      chk("tmo{ir,ren,err}", {bus.i_ready, bus.mem_ren, bus.err},
          {e == TMO, e < TMO, e == TMO});
      if (e == TMO) chk("tmo_rdata", bus.i_rdata, 32'hDEADBEEF);
    end
    bus.i_req = 1'b0; stall = 1'b0; last_g = 1'b0; exp_i = 32'hDEADBEEF;
`else
    for (int e = 0; e < 3 * TMO; e++) begin
      step();
      chk("hang{ir,ren,err}", {bus.i_ready, bus.mem_ren, bus.err}, 3'b010);
    end
    stall = 1'b0;
    do_reset();
`endif

    // Back-to-back: make I the last grant, then D read + I read together
    do_txn(1'b1, mk_i(32'h1008), 1'b0, mk_d(0, 0, 0, 0), 0);
    do_txn(1'b1, mk_i(32'h100), 1'b1, mk_d(1'b0, 32'h2004, 0, 4'hF), 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      ui = $urandom_range(0, 2);
      ud = (ui == 0) ? 1 : $urandom_range(0, 1);
      ia = mk_i(rnd_addr());
      da = mk_d(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom_range(1, 15)));
      do_txn(ui != 0, ia, ud != 0, da, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing memory between the instruction-side and data-side cache-miss paths.
- Sits between the two cache controllers and the memory model.
- Accepts one request per side, arbitrates round-robin, and drives the memory strobes until the memory signals completion.
- Returns read data with a one-cycle ready pulse to the winning side only.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-side read request; held high until i_ready.
- i_addr  in  ADDR_W  instruction-side byte address.
- i_ready  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  instruction-side read data.
- d_req  in  1  data-side request; held high until d_ready.
- d_wen  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data-side byte address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables for writes.
- d_ready  out  1  one-cycle pulse: d_rdata valid, or write complete.
- d_rdata  out  DATA_W  data-side read data.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_be  out  DATA_W/8  memory byte enables; all ones on reads.
- mem_rdata  in  DATA_W  memory read data; valid when mem_done is high.
- mem_done  in  1  memory completion for the current access.
- err  out  1  timeout flag, qualifies ready (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0: strobes, mem_* buses, i_ready/d_ready, i_rdata/d_rdata, err.
  - last_grant is set to D, so I wins the first tie.
  - A reset mid-access drops the strobes immediately; no ready is issued for the aborted access.
- State IDLE:
  - Sample i_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: grant the side opposite last_grant.
  - On grant, register address, wdata and be; update last_grant; go to BUSY.
  - Neither asserted: stay in IDLE.
- State BUSY:
  - Strobes are asserted from the first BUSY cycle, i.e. one cycle after the request is sampled.
  - I grant: mem_ren=1. D grant: mem_ren=!d_wen, mem_wen=d_wen, using values captured at grant.
  - mem_* outputs are held stable for the whole of BUSY.
  - mem_done=1: capture mem_rdata into the winner's rdata register (reads only), deassert strobes, go to RESP.
- State RESP:
  - Winner's ready=1 for exactly one cycle; then return to IDLE.
  - Loser's ready stays 0.
  - rdata registers hold their value until the next completion on the same side.
- Requester rule:
  - A requester drops req on the edge where it sees ready=1.
  - The IDLE cycle after RESP may therefore legally re-arbitrate immediately.
- Latency: minimum 3 cycles from req sampled to ready (IDLE, BUSY with mem_done=1 in its first cycle, RESP). In general, 2 + number of BUSY cycles.
- Request changes while it is pending or granted are not sampled; captured values are used.
- mem_done outside BUSY is ignored.
- A request arriving during BUSY/RESP waits. Starvation is bounded by round-robin to one foreign access.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without mem_done: drop strobes, load the winner's rdata with 32'hDEADBEEF, set err=1 for the RESP cycle, go to RESP.
  - err is 0 at all other times.
- Not defined:
  - No counter exists; BUSY waits indefinitely.
  - err is tied to 0.

Test Plan:
- I only: i_addr=0x100, mem_done one cycle after strobe, mem_rdata=0x00500093 -> mem_ren=1 with mem_addr=0x100; i_ready pulses once, 4 cycles after the request was sampled; i_rdata=0x00500093; d_ready stays 0.
- D write: d_addr=0x2004, d_wdata=0xCAFEF00D, d_be=4'b0011 -> mem_wen=1, mem_ren=0, mem_be=4'b0011 held through BUSY; d_ready one pulse; d_rdata unchanged.
- Tie after reset: i_req=d_req=1 in the same cycle -> I granted first; D granted on the IDLE cycle after I's RESP; the next tie grants I again.
- Reset mid-BUSY: assert reset=0 while mem_ren=1 -> mem_ren drops without waiting for a clock edge, no ready pulse; after release, a fresh d_req to 0x40 completes normally.
- Timeout (macro defined, TIMEOUT=8): I request, mem_done held 0 -> strobe drops after 8 BUSY cycles; i_ready=1 with err=1 and i_rdata=0xDEADBEEF. Without the macro, the same stimulus leaves the block in BUSY with err=0.
- Back-to-back: D read then I read, both present, mem_done in the first BUSY cycle -> two ready pulses 3 cycles apart; mem_rdata of each access is routed to its own side.
